// File: rtl/ser8_tx.sv
// ---------------------------------------------------------------------------
// ser8_tx : parallel-in / serial-out byte transmitter
//
// A one-entry hold buffer sits in front of an 8-bit shift register, so a new
// byte can be queued while the current one is still shifting.  Back-to-back
// bytes therefore stream with no idle cycle between them.
//
// Each serial bit is held for DIV clock cycles.
//
// Ports
//   CK    in   clock, all state updates on the rising edge
//   RSTN  in   synchronous active-low reset
//   I     in   [7:0] parallel byte to transmit
//   LD    in   load request, byte taken on an edge where LD=1 and RDY=1
//   RDY   out  hold buffer empty (registered, no path from LD)
//   SO    out  serial data bit
//   SE    out  high while SO carries a valid bit
//   BS    out  one-cycle strobe in the first cycle of every bit
//   DONE  out  one-cycle pulse in the final cycle of a byte's last bit
//   BUSY  out  shifter active or hold buffer full
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | shifter empty, outputs quiet, waiting for hold buffer to fill
// SHIFT | shift register driving SO, div/bit counters running
// ---------------------------------------------------------------------------
module ser8_tx #(
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       CK,
  input  logic       RSTN,
  input  logic [7:0] I,
  input  logic       LD,
  output logic       RDY,
  output logic       SO,
  output logic       SE,
  output logic       BS,
  output logic       DONE,
  output logic       BUSY
);

  // Keep the divider counter at least one bit wide so DIV=1 still elaborates.
  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        r_state;
  logic [7:0]    r_hold;
  logic          r_hold_full;
  logic          r_rdy;
  logic [7:0]    r_sh;
  logic [CW-1:0] r_div_cnt;
  logic [2:0]    r_bit_cnt;

  state_t        w_state_nxt;
  logic [7:0]    w_hold_nxt;
  logic          w_hold_full_nxt;
  logic [7:0]    w_sh_nxt;
  logic [CW-1:0] w_div_cnt_nxt;
  logic [2:0]    w_bit_cnt_nxt;

  logic          w_accept;
  logic          w_div_last;
  logic          w_bit_last;
  logic [7:0]    w_sh_shifted;

  logic          w_so;
  logic          w_se;
  logic          w_bs;
  logic          w_done;

  assign w_accept   = LD & r_rdy;
  assign w_div_last = (r_div_cnt == DIV_LAST);
  assign w_bit_last = (r_bit_cnt == 3'd7);

  // Shift toward whichever end feeds SO; vacated bits fill with zero.
  assign w_sh_shifted = MSB_FIRST ? {r_sh[6:0], 1'b0} : {1'b0, r_sh[7:1]};

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      r_state     <= IDLE;
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
      r_rdy       <= 1'b1;
      r_sh        <= 8'h00;
      r_div_cnt   <= '0;
      r_bit_cnt   <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_rdy       <= ~w_hold_full_nxt;
      r_sh        <= w_sh_nxt;
      r_div_cnt   <= w_div_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_sh_nxt        = r_sh;
    w_div_cnt_nxt   = r_div_cnt;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_so            = 1'b0;
    w_se            = 1'b0;
    w_bs            = 1'b0;
    w_done          = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_state_nxt     = SHIFT;
          w_sh_nxt        = r_hold;
          w_hold_full_nxt = 1'b0;
          w_div_cnt_nxt   = '0;
          w_bit_cnt_nxt   = 3'd0;
        end
      end

      SHIFT: begin
        w_so   = MSB_FIRST ? r_sh[7] : r_sh[0];
        w_se   = 1'b1;
        w_bs   = (r_div_cnt == '0);
        w_done = w_div_last & w_bit_last;

        if (w_div_last) begin
          w_div_cnt_nxt = '0;
          if (w_bit_last) begin
            w_bit_cnt_nxt = 3'd0;
            if (r_hold_full) begin
              // Reload straight from the hold buffer so SE never drops.
              w_sh_nxt        = r_hold;
              w_hold_full_nxt = 1'b0;
            end else begin
              w_state_nxt = IDLE;
              w_sh_nxt    = 8'h00;
            end
          end else begin
            w_sh_nxt      = w_sh_shifted;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // An accept only happens with the buffer empty, while a load/reload only
    // happens with it full, so the two never collide on the same edge.
    if (w_accept) begin
      w_hold_nxt      = I;
      w_hold_full_nxt = 1'b1;
    end
  end

  assign RDY  = r_rdy;
  assign SO   = w_so;
  assign SE   = w_se;
  assign BS   = w_bs;
  assign DONE = w_done;
  assign BUSY = (r_state == SHIFT) | r_hold_full;

endmodule
